hazard_fwd_ctrl: RTL and testbench

- Pipeline hazard and forwarding controller for the 5-stage MIPS core.
- Drives the 2-bit selects of the two EX-stage 4:1 operand muxes (A and B).
- Detects load-use hazards; sequences the multi-cycle mul/div unit with a busy counter.
- Generates PC / IF-ID stall and IF-ID / ID-EX flush controls for taken branches.

---
 rtl/hazard_fwd_ctrl.sv | 154 +++++++++++++++
 tb/tb_hazard_fwd_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_fwd_ctrl.sv
// rtl/hazard_fwd_ctrl.sv - hazard detection, operand forwarding and mul/div sequencing for the 5-stage core
module hazard_fwd_ctrl #(
  parameter int REG_ADDR      = 5,
  parameter int MULDIV_CYCLES = 32,
  parameter int CNT_W         = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [REG_ADDR-1:0] id_rs,
  input  logic [REG_ADDR-1:0] id_rt,
  input  logic                id_uses_rs,
  input  logic                id_uses_rt,
  input  logic                id_is_muldiv,
  input  logic                id_reads_hilo,
  input  logic [REG_ADDR-1:0] ex_rs,
  input  logic [REG_ADDR-1:0] ex_rt,
  input  logic [REG_ADDR-1:0] ex_rd,
  input  logic                ex_reg_write,
  input  logic                ex_mem_read,
  input  logic [REG_ADDR-1:0] mem_rd,
  input  logic                mem_reg_write,
  input  logic [REG_ADDR-1:0] wb_rd,
  input  logic                wb_reg_write,
  input  logic                ex_branch_taken,
  output logic [1:0]          fwd_a_sel,
  output logic [1:0]          fwd_b_sel,
  output logic                pc_stall,
  output logic                ifid_stall,
  output logic                ifid_flush,
  output logic                idex_flush,
  output logic                muldiv_start,
  output logic                muldiv_busy
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [REG_ADDR-1:0] R0    = '0;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [REG_ADDR-1:0] wb2_rd;
  logic                wb2_valid;

  logic [1:0] sel_a;
  logic [1:0] sel_b;
  logic       load_use;
  logic       md_stall;
  logic       stall;
  logic       start_req;

  // An EX-stage result is not yet available to forward, so ex_reg_write has no consumer here.
  logic unused_inputs;
  assign unused_inputs = ex_reg_write;

  // Forwarding priority: youngest producer wins; register 0 never forwards.
  function automatic logic [1:0] pick_src(
    input logic [REG_ADDR-1:0] src,
    input logic [REG_ADDR-1:0] m_rd,
    input logic                m_we,
    input logic [REG_ADDR-1:0] w_rd,
    input logic                w_we,
    input logic [REG_ADDR-1:0] w2_rd,
    input logic                w2_valid
  );
    if (m_we && (m_rd != R0) && (m_rd == src)) begin
      return 2'b01;
    end else if (w_we && (w_rd != R0) && (w_rd == src)) begin
      return 2'b10;
    end else if (w2_valid && (w2_rd == src)) begin
      return 2'b11;
    end else begin
      return 2'b00;
    end
  endfunction

  // Operand selects and stall sources, all combinational from inputs and current state.
  always_comb begin
    sel_a = pick_src(ex_rs, mem_rd, mem_reg_write, wb_rd, wb_reg_write, wb2_rd, wb2_valid);
    sel_b = pick_src(ex_rt, mem_rd, mem_reg_write, wb_rd, wb_reg_write, wb2_rd, wb2_valid);
    load_use = ex_mem_read && (ex_rd != R0) &&
               ((id_uses_rs && (ex_rd == id_rs)) || (id_uses_rt && (ex_rd == id_rt)));
    md_stall  = (state == MD_BUSY) && (id_is_muldiv || id_reads_hilo);
    // A taken branch flushes ID, so its stall requests are moot.
    stall     = (load_use || md_stall) && !ex_branch_taken;
    start_req = (state == RUN) && id_is_muldiv && !load_use && !ex_branch_taken;
  end

  // Output drive; everything is held at 0 while reset is asserted.
  always_comb begin
    fwd_a_sel    = 2'b00;
    fwd_b_sel    = 2'b00;
    pc_stall     = 1'b0;
    ifid_stall   = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    muldiv_start = 1'b0;
    muldiv_busy  = 1'b0;
    if (rst_n) begin
      fwd_a_sel    = sel_a;
      fwd_b_sel    = sel_b;
      pc_stall     = stall;
      ifid_stall   = stall;
      ifid_flush   = ex_branch_taken;
      idex_flush   = stall || ex_branch_taken;
      muldiv_start = start_req;
      muldiv_busy  = (state == MD_BUSY);
    end
  end

  // Track the register retired last cycle so a WB2 bypass can cover the register-file write latency.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb2_rd    <= '0;
      wb2_valid <= 1'b0;
    end else begin
      wb2_rd    <= wb_rd;
      wb2_valid <= wb_reg_write && (wb_rd != R0);
    end
  end

  // Mul/div occupancy FSM; a taken branch does not abort an issued operation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      case (state)
        RUN: begin
          if (start_req) begin
            cnt   <= CNT_LOAD;
            state <= MD_BUSY;
          end
        end
        MD_BUSY: begin
          if (cnt == '0) begin
            state <= RUN;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        default: begin
          state <= RUN;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// tb/tb_hazard_fwd_ctrl.sv - directed self-checking bench for hazard_fwd_ctrl
module tb_hazard_fwd_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic       id_uses_rs, id_uses_rt, id_is_muldiv, id_reads_hilo;
  logic       ex_reg_write, ex_mem_read, mem_reg_write, wb_reg_write, ex_branch_taken;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic       pc_stall, ifid_stall, ifid_flush, idex_flush, muldiv_start, muldiv_busy;

  int checks   = 0;
  int failures = 0;

  hazard_fwd_ctrl #(
    .REG_ADDR(5),
    .MULDIV_CYCLES(4),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .id_rs(id_rs),
    .id_rt(id_rt),
    .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt),
    .id_is_muldiv(id_is_muldiv),
    .id_reads_hilo(id_reads_hilo),
    .ex_rs(ex_rs),
    .ex_rt(ex_rt),
    .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read),
    .mem_rd(mem_rd),
    .mem_reg_write(mem_reg_write),
    .wb_rd(wb_rd),
    .wb_reg_write(wb_reg_write),
    .ex_branch_taken(ex_branch_taken),
    .fwd_a_sel(fwd_a_sel),
    .fwd_b_sel(fwd_b_sel),
    .pc_stall(pc_stall),
    .ifid_stall(ifid_stall),
    .ifid_flush(ifid_flush),
    .idex_flush(idex_flush),
    .muldiv_start(muldiv_start),
    .muldiv_busy(muldiv_busy)
  );

  always #5 clk = ~clk;

  // Packed view: {fwd_a, fwd_b, pc_stall, ifid_stall, ifid_flush, idex_flush, start, busy}
  function automatic logic [9:0] outs();
    return {fwd_a_sel, fwd_b_sel, pc_stall, ifid_stall, ifid_flush, idex_flush,
            muldiv_start, muldiv_busy};
  endfunction

  task automatic chk(input string tag, input logic [9:0] exp);
    logic [9:0] obs;
    obs = outs();
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs = '0; id_rt = '0; ex_rs = '0; ex_rt = '0; ex_rd = '0; mem_rd = '0; wb_rd = '0;
    id_uses_rs = 0; id_uses_rt = 0; id_is_muldiv = 0; id_reads_hilo = 0;
    ex_reg_write = 0; ex_mem_read = 0; mem_reg_write = 0; wb_reg_write = 0;
    ex_branch_taken = 0;
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    // Reset: forwarding match and mul/div request must both be masked
    ex_rs = 5'd5; mem_rd = 5'd5; mem_reg_write = 1; id_is_muldiv = 1;
    tick();
    chk("reset_outputs", 10'b00_00_0000_00);
    clear_inputs();
    rst_n = 1'b1;
    #1 chk("idle", 10'b00_00_0000_00);

    // Forwarding priority chain on operand A
    tick();
    mem_rd = 5'd5; mem_reg_write = 1; wb_rd = 5'd5; wb_reg_write = 1; ex_rs = 5'd5; ex_rt = 5'd6;
    #1 chk("fwd_a_mem", 10'b01_00_0000_00);
    mem_reg_write = 0;
    #1 chk("fwd_a_wb", 10'b10_00_0000_00);
    tick();
    wb_reg_write = 0;
    #1 chk("fwd_a_wb2", 10'b11_00_0000_00);
    tick();
    #1 chk("fwd_a_none", 10'b00_00_0000_00);
    mem_rd = 5'd6; mem_reg_write = 1;
    #1 chk("fwd_b_mem", 10'b00_01_0000_00);

    // Register 0 never forwards and never causes a load-use stall
    clear_inputs();
    ex_reg_write = 1; ex_mem_read = 1; mem_reg_write = 1; wb_reg_write = 1;
    id_uses_rs = 1; id_uses_rt = 1;
    #1 chk("zero_reg", 10'b00_00_0000_00);
    tick();
    #1 chk("zero_reg_wb2", 10'b00_00_0000_00);

    // Load-use hazard
    clear_inputs();
    tick();
    ex_mem_read = 1; ex_reg_write = 1; ex_rd = 5'd8; id_rt = 5'd8; id_uses_rt = 1;
    #1 chk("load_use_rt", 10'b00_00_1101_00);
    tick();
    ex_mem_read = 0; ex_reg_write = 0; ex_rd = 5'd0;
    #1 chk("load_advanced", 10'b00_00_0000_00);
    ex_mem_read = 1; ex_reg_write = 1; ex_rd = 5'd8; id_uses_rt = 0;
    #1 chk("load_rt_unused", 10'b00_00_0000_00);
    id_rs = 5'd8; id_uses_rs = 1;
    #1 chk("load_use_rs", 10'b00_00_1101_00);

    // Mul/div sequencing (4-cycle unit)
    clear_inputs();
    tick();
    id_is_muldiv = 1;
    #1 chk("md_start", 10'b00_00_0000_10);
    tick();
    id_is_muldiv = 0; id_reads_hilo = 1;
    #1 chk("md_busy1_mfhi", 10'b00_00_1101_01);
    tick();
    id_reads_hilo = 0; id_rs = 5'd3; id_uses_rs = 1;
    #1 chk("md_busy2_add", 10'b00_00_0000_01);
    tick();
    id_reads_hilo = 1; ex_mem_read = 1; ex_rd = 5'd3;
    #1 chk("md_busy3_both", 10'b00_00_1101_01);
    tick();
    id_reads_hilo = 0; ex_mem_read = 0; ex_rd = 5'd0; id_uses_rs = 0; id_is_muldiv = 1;
    #1 chk("md_busy4_muldiv", 10'b00_00_1101_01);
    tick();
    #1 chk("md_reissue", 10'b00_00_0000_10);
    tick();
    id_is_muldiv = 0;
    #1 chk("md2_busy1", 10'b00_00_0000_01);
    tick();

    // Reset in MD_BUSY with counter at 2
    rst_n = 0; id_reads_hilo = 1; wb_rd = 5'd9; wb_reg_write = 1; ex_rs = 5'd9;
    #1 chk("rst_mid_md", 10'b00_00_0000_00);
    tick();
    rst_n = 1; id_reads_hilo = 0; wb_reg_write = 0;
    #1 chk("post_rst", 10'b00_00_0000_00);
    tick();
    ex_rs = 5'd0; id_is_muldiv = 1;
    #1 chk("post_rst_start", 10'b00_00_0000_10);
    tick();

    // Branch during MD_BUSY flushes but does not abort the operation
    id_is_muldiv = 0; id_reads_hilo = 1; ex_branch_taken = 1;
    #1 chk("br_in_md", 10'b00_00_0011_01);
    tick();
    id_reads_hilo = 0; ex_branch_taken = 0;
    #1 chk("md_continues", 10'b00_00_0000_01);
    tick();
    tick();
    tick();

    // Branch overrides load-use and suppresses mul/div issue
    ex_branch_taken = 1; ex_mem_read = 1; ex_rd = 5'd8; id_rt = 5'd8; id_uses_rt = 1;
    id_is_muldiv = 1;
    #1 chk("br_over_load", 10'b00_00_0011_00);
    tick();
    clear_inputs();
    #1 chk("br_no_issue", 10'b00_00_0000_00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
